// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//   Far-end bit-error-rate checker for the 4-bit XNOR LFSR pattern source
//   (next = {s[2:0], ~(s[3]^s[2])}, period 15, lockup state 1111).
//   It self-synchronises to the received out[0] stream, then free-runs a
//   local copy of the generator ("flywheel"). Each received bit that
//   disagrees with the local prediction is flagged and counted.
//
// Ports
//   clc         in   clock, all logic on the rising edge
//   rst         in   synchronous active-high reset
//   din         in   received serial bit
//   din_valid   in   din qualifier; nothing advances while low
//   clr_cnt     in   synchronous clear of err_cnt
//   locked      out  high while in LOCKED
//   err         out  one-cycle pulse per mismatched bit while LOCKED
//   err_cnt     out  saturating error count since reset/clear
//   sync_state  out  ACQUIRE=00, SYNC=01, LOCKED=10
// ---------------------------------------------------------------------------
module lfsr_checker #(
    parameter int SYNC_LEN    = 8,
    parameter int LOSS_THRESH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clc,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       sync_state
);

    localparam int MATCH_W = $clog2(SYNC_LEN + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESH + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(SYNC_LEN - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {
        ACQUIRE = 2'b00,
        SYNC    = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [3:0]         r_shift,     w_shift_nxt;
    logic [1:0]         r_acq_cnt,   w_acq_nxt;
    logic [MATCH_W-1:0] r_match_cnt, w_match_nxt;
    logic [MISS_W-1:0]  r_miss_cnt,  w_miss_nxt;
    logic               r_err,       w_err_nxt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_pred;
    logic [3:0]         w_shift_in;
    logic [1:0]         w_state_bits;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Local prediction of the next generator output bit.
    assign w_pred     = ~(r_shift[3] ^ r_shift[2]);
    assign w_shift_in = {r_shift[2:0], din};

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_acq_nxt   = r_acq_cnt;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_err_nxt   = 1'b0;
        if (din_valid) begin
            case (r_state)
                ACQUIRE: begin
                    w_shift_nxt = w_shift_in;
                    if (r_acq_cnt == 2'd3) begin
                        // Four bits loaded; an all-ones register would be
                        // the lockup state, so keep shifting instead.
                        if (w_shift_in != 4'b1111) begin
                            w_state_nxt = SYNC;
                            w_match_nxt = '0;
                        end
                    end else begin
                        w_acq_nxt = r_acq_cnt + 2'd1;
                    end
                end
                SYNC: begin
                    w_shift_nxt = w_shift_in;
                    if (din == w_pred) begin
                        if (r_match_cnt == MATCH_LAST) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end else begin
                            w_match_nxt = r_match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        w_state_nxt = ACQUIRE;
                        w_acq_nxt   = 2'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the received bit never enters the register,
                    // so a single line error cannot corrupt later predictions.
                    w_shift_nxt = {r_shift[2:0], w_pred};
                    if (din != w_pred) begin
                        w_err_nxt = 1'b1;
                        if (r_miss_cnt == MISS_LAST) begin
                            w_state_nxt = ACQUIRE;
                            w_acq_nxt   = 2'd0;
                        end else begin
                            w_miss_nxt = r_miss_cnt + MISS_W'(1);
                        end
                    end else begin
                        w_miss_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ACQUIRE;
                    w_acq_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clc) begin
        if (rst) begin
            r_state     <= ACQUIRE;
            r_shift     <= 4'b0000;
            r_acq_cnt   <= 2'd0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_acq_cnt   <= w_acq_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_err       <= w_err_nxt;
            // Clear beats a same-cycle increment; the err pulse still fires.
            if (clr_cnt) begin
                r_err_cnt <= '0;
            end else if (w_err_nxt) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    assign w_state_bits = r_state;
    assign locked       = (r_state == LOCKED);
    assign sync_state   = (w_state_bits == 2'b11) ? 2'b00 : w_state_bits;
    assign err          = r_err;
    assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//   Directed bench for lfsr_checker (instantiated with CNT_W=4 so counter
//   saturation is reachable quickly). A 4-bit XNOR LFSR source drives din.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int CNT_W = 4;

    logic             clc = 1'b0;
    logic             rst;
    logic             din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       sync_state;

    logic [3:0] g;          // generator state
    int n_vec  = 0;
    int n_miss = 0;

    lfsr_checker #(.SYNC_LEN(8), .LOSS_THRESH(3), .CNT_W(CNT_W)) u_dut (
        .clc        (clc),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .clr_cnt    (clr_cnt),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt),
        .sync_state (sync_state)
    );

    always #5 clc = ~clc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one input set across one rising edge; outputs sampled 1ns later.
    task automatic clk_bit(input logic d, input logic v);
        din       = d;
        din_valid = v;
        @(posedge clc);
        #1;
    endtask

    // Advance the generator and send its new out[0], optionally inverted.
    task automatic gen_bit(input logic flip);
        g = {g[2:0], ~(g[3] ^ g[2])};
        clk_bit(g[0] ^ flip, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk_bit(1'b0, 1'b0);
        rst = 1'b0;
        g   = 4'b0000;
    endtask

    initial begin
        int errs;
        int bad_state;
        logic [1:0] held;
        rst = 1'b0; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
        g = 4'b0000;
        @(negedge clc);

        // Reset state
        do_reset();
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_errcnt", 32'(err_cnt), 0);
        check("rst_state", 32'(sync_state), 0);

        // 1: clean stream, lock after 12th valid bit
        errs = 0;
        for (int i = 1; i <= 300; i++) begin
            gen_bit(1'b0);
            if (i == 3)  check("t1_state3", 32'(sync_state), 32'h0);
            if (i == 4)  check("t1_state4", 32'(sync_state), 32'h1);
            if (i == 11) begin
                check("t1_lock11", 32'(locked), 0);
                check("t1_state11", 32'(sync_state), 32'h1);
            end
            if (i == 12) begin
                check("t1_lock12", 32'(locked), 1);
                check("t1_state12", 32'(sync_state), 32'h2);
            end
            errs += int'(err);
        end
        check("t1_errs", 32'(errs), 0);
        check("t1_errcnt", 32'(err_cnt), 0);
        check("t1_locked", 32'(locked), 1);

        // 2: single flip while locked
        gen_bit(1'b1);
        check("t2_err", 32'(err), 1);
        check("t2_errcnt", 32'(err_cnt), 1);
        check("t2_locked", 32'(locked), 1);
        errs = 0;
        for (int i = 0; i < 14; i++) begin
            gen_bit(1'b0);
            errs += int'(err);
        end
        check("t2_after_errs", 32'(errs), 0);
        check("t2_after_cnt", 32'(err_cnt), 1);
        check("t2_after_lock", 32'(locked), 1);

        // 3: burst of 3 drops lock, clean stream relocks after 12 bits
        clr_cnt = 1'b1;
        gen_bit(1'b0);
        clr_cnt = 1'b0;
        check("t3_clr", 32'(err_cnt), 0);
        gen_bit(1'b1);
        check("t3_b1_lock", 32'(locked), 1);
        gen_bit(1'b1);
        check("t3_b2_lock", 32'(locked), 1);
        check("t3_b2_cnt", 32'(err_cnt), 2);
        gen_bit(1'b1);
        check("t3_b3_err", 32'(err), 1);
        check("t3_b3_cnt", 32'(err_cnt), 3);
        check("t3_b3_lock", 32'(locked), 0);
        check("t3_b3_state", 32'(sync_state), 0);
        for (int i = 1; i <= 12; i++) begin
            gen_bit(1'b0);
            if (i == 11) check("t3_relock11", 32'(locked), 0);
            if (i == 12) check("t3_relock12", 32'(locked), 1);
        end
        check("t3_cnt_end", 32'(err_cnt), 3);

        // 4: constant ones is the lockup pattern, never leaves ACQUIRE
        do_reset();
        bad_state = 0;
        for (int i = 0; i < 100; i++) begin
            clk_bit(1'b1, 1'b1);
            if (sync_state != 2'b00 || locked) bad_state++;
        end
        check("t4_bad_cycles", 32'(bad_state), 0);
        check("t4_state", 32'(sync_state), 0);
        check("t4_errcnt", 32'(err_cnt), 0);

        // 5: alternate valid / invalid cycles; invalid din is garbage
        do_reset();
        errs = 0;
        bad_state = 0;
        for (int k = 1; k <= 12; k++) begin
            gen_bit(1'b0);
            errs += int'(err);
            if (k == 11) check("t5_lock11", 32'(locked), 0);
            if (k == 12) check("t5_lock12", 32'(locked), 1);
            held = sync_state;
            clk_bit(~g[0], 1'b0);
            errs += int'(err);
            if (sync_state != held) bad_state++;
        end
        check("t5_errs", 32'(errs), 0);
        check("t5_hold", 32'(bad_state), 0);
        // err pulse must clear on an idle cycle
        gen_bit(1'b1);
        check("t5_err_pulse", 32'(err), 1);
        clk_bit(1'b0, 1'b0);
        check("t5_err_idle", 32'(err), 0);
        check("t5_cnt", 32'(err_cnt), 1);

        // 6: saturation, clear, reset mid-lock
        do_reset();
        for (int i = 0; i < 12; i++) gen_bit(1'b0);
        check("t6_locked", 32'(locked), 1);
        for (int i = 0; i < 40; i++) begin
            gen_bit(i[0] == 1'b0);
            if (i == 28) check("t6_cnt15", 32'(err_cnt), 15);
            if (i == 30) check("t6_sat16", 32'(err_cnt), 15);
        end
        check("t6_lock_held", 32'(locked), 1);
        check("t6_sat_end", 32'(err_cnt), 15);
        clr_cnt = 1'b1;
        gen_bit(1'b0);
        clr_cnt = 1'b0;
        check("t6_clr", 32'(err_cnt), 0);
        clr_cnt = 1'b1;
        gen_bit(1'b1);
        clr_cnt = 1'b0;
        check("t6_clr_wins_cnt", 32'(err_cnt), 0);
        check("t6_clr_wins_err", 32'(err), 1);
        gen_bit(1'b0);
        gen_bit(1'b1);
        check("t6_inc_after", 32'(err_cnt), 1);
        rst = 1'b1;
        gen_bit(1'b1);
        rst = 1'b0;
        check("t6_rst_locked", 32'(locked), 0);
        check("t6_rst_err", 32'(err), 0);
        check("t6_rst_state", 32'(sync_state), 0);
        check("t6_rst_cnt", 32'(err_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
